// File: rtl/led_ctrl_pkg.sv
// Shared encodings and constants for the DE0 LED mode sequencer.
// Mode/state encodings, bounce seed and the mode rotation helper.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_UP     = 2'd1;
    localparam logic [1:0] MODE_DOWN   = 2'd2;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    localparam logic [7:0] BOUNCE_SEED = 8'h07;
    localparam int         NUM_SPEEDS  = 4;
    localparam int         PRESC_W     = 26;

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            MODE_BOUNCE: r = MODE_UP;
            MODE_UP:     r = MODE_DOWN;
            MODE_DOWN:   r = MODE_BOUNCE;
            default:     r = MODE_BOUNCE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_mode_controller_if.sv
// Control bundle from the sequencer to the 8-bit LED counter/shifter datapath.
interface led_mode_controller_if;
    logic       cnt_enable;
    logic       cnt_load_n;
    logic       cnt_direction;
    logic [7:0] cnt_parallel_in;
    logic       cnt_step;

    modport master (
        output cnt_enable, cnt_load_n, cnt_direction, cnt_parallel_in, cnt_step
    );

    modport slave (
        input cnt_enable, cnt_load_n, cnt_direction, cnt_parallel_in, cnt_step
    );
endinterface

// File: rtl/led_mode_controller_button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted released-to-pressed transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples disagreeing with the accepted (pressed-high) level.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = {CW{1'b0}};
        if ((~sync2_q) == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            press_d = ~level_q;
            cnt_d   = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Registers; reset leaves the button seen as released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/led_mode_controller.sv
// Mode/speed/pause sequencer driving the LED datapath: button conditioning,
// control FSM, run-time selectable step prescaler and registered outputs.
import led_ctrl_pkg::*;

module led_mode_controller #(
    parameter int BASE_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        btn_mode_n,
    input  logic                        btn_speed_n,
    input  logic                        btn_pause_n,
    input  logic [7:0]                  sw_pattern,
    led_mode_controller_if.master       cnt,
    output logic [1:0]                  mode,
    output logic [1:0]                  speed,
    output logic                        paused
);
    localparam logic [PRESC_W-1:0] BASE = PRESC_W'(BASE_DIV);

    logic mode_evt, speed_evt, pause_evt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_mode_n), .press(mode_evt));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_speed_n), .press(speed_evt));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_pause_n), .press(pause_evt));

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         speed_q, speed_d;
    logic               paused_q, paused_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] period_last;
    logic               tick;
    logic               enable_q, enable_d;
    logic               load_n_q, load_n_d;
    logic               dir_q, dir_d;
    logic [7:0]         pin_q, pin_d;
    logic               step_q, step_d;

    // Flag updates and next state; a mode event always forces LOAD.
    always_comb begin
        mode_d   = mode_evt ? next_mode(mode_q) : mode_q;
        speed_d  = speed_q;
        if (speed_evt) begin
            speed_d = (speed_q == 2'(NUM_SPEEDS - 1)) ? 2'd0 : speed_q + 2'd1;
        end else begin
            speed_d = speed_q;
        end
        paused_d = paused_q ^ pause_evt;
        state_d  = state_q;
        if (mode_evt) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                INIT:             state_d = LOAD;
                LOAD, RUN, PAUSE: state_d = paused_d ? PAUSE : RUN;
                default:          state_d = INIT;
            endcase
        end
    end

    // Prescaler and Moore output decode of the state being entered.
    always_comb begin
        period_last = (BASE >> speed_q) - {{(PRESC_W-1){1'b0}}, 1'b1};
        tick        = (state_q == RUN) && (presc_q == period_last) && !speed_evt;
        if ((state_q == RUN) && (state_d == RUN) && !speed_evt) begin
            presc_d = tick ? {PRESC_W{1'b0}} : presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end else begin
            presc_d = {PRESC_W{1'b0}};
        end

        enable_d = 1'b0;
        load_n_d = 1'b1;
        step_d   = 1'b0;
        case (state_d)
            LOAD: begin
                enable_d = 1'b1;
                load_n_d = 1'b0;
            end
            RUN: begin
                enable_d = 1'b1;
                step_d   = tick;
            end
            default: begin
                enable_d = 1'b0;
            end
        endcase

        dir_d = (mode_d != MODE_DOWN);
        if (state_d == LOAD) begin
            pin_d = (mode_d == MODE_BOUNCE) ? BOUNCE_SEED : sw_pattern;
        end else begin
            pin_d = pin_q;
        end
    end

    // State, flags, prescaler and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= INIT;
            mode_q   <= MODE_BOUNCE;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            presc_q  <= {PRESC_W{1'b0}};
            enable_q <= 1'b0;
            load_n_q <= 1'b1;
            dir_q    <= 1'b1;
            pin_q    <= BOUNCE_SEED;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            presc_q  <= presc_d;
            enable_q <= enable_d;
            load_n_q <= load_n_d;
            dir_q    <= dir_d;
            pin_q    <= pin_d;
            step_q   <= step_d;
        end
    end

    assign cnt.cnt_enable      = enable_q;
    assign cnt.cnt_load_n      = load_n_q;
    assign cnt.cnt_direction   = dir_q;
    assign cnt.cnt_parallel_in = pin_q;
    assign cnt.cnt_step        = step_q;
    assign mode                = mode_q;
    assign speed               = speed_q;
    assign paused              = paused_q;
endmodule

// File: tb/tb_led_mode_controller.sv
// Bench for led_mode_controller: directed scenarios with literal expectations
// plus randomized button traffic checked every cycle against a behavioural model.
module tb_led_mode_controller;
    localparam int BASE_DIV = 16;
    localparam int DB       = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode_n = 1'b1, btn_speed_n = 1'b1, btn_pause_n = 1'b1;
    logic [7:0] sw_pattern = 8'h00;
    logic [1:0] mode, speed;
    logic       paused;

    led_mode_controller_if cnt_if ();

    led_mode_controller #(.BASE_DIV(BASE_DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_mode_n(btn_mode_n), .btn_speed_n(btn_speed_n), .btn_pause_n(btn_pause_n),
        .sw_pattern(sw_pattern), .cnt(cnt_if),
        .mode(mode), .speed(speed), .paused(paused));

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // ---------------- behavioural model ----------------
    // Button i is pressed-accepted when the last DB synchronized samples (raw
    // delayed by 2 edges) all disagree with the accepted level. Steps are
    // counted down from the period whenever the sequencer (re)enters running.
    bit        m_valid = 1'b0;
    bit        m_init, m_load, m_paused;
    int        m_mode, m_speed, m_cd;
    bit        e_enable, e_load_n, e_dir, e_step;
    logic [7:0] e_pin;
    bit [7:0]  h [3];
    bit        lvl [3];
    bit        evt [3];

    always @(posedge clk) begin : model
        bit run_before, next_load, next_run, new_paused, all_set;
        int new_mode, new_speed;
        logic [2:0] raw;
        raw = {btn_pause_n, btn_speed_n, btn_mode_n};
        if (!reset_n) begin
            m_valid = 1'b1; m_init = 1'b1; m_load = 1'b0; m_paused = 1'b0;
            m_mode = 0; m_speed = 0; m_cd = 0;
            e_enable = 1'b0; e_load_n = 1'b1; e_dir = 1'b1; e_step = 1'b0; e_pin = 8'h07;
            for (int b = 0; b < 3; b++) begin h[b] = 8'h00; lvl[b] = 1'b0; evt[b] = 1'b0; end
        end else begin
            run_before = !m_init && !m_load && !m_paused;
            new_mode   = evt[0] ? (m_mode + 1) % 3 : m_mode;
            new_speed  = evt[1] ? (m_speed + 1) % 4 : m_speed;
            new_paused = m_paused ^ evt[2];
            next_load  = m_init || evt[0];
            next_run   = !next_load && !new_paused;
            e_step     = 1'b0;
            if (next_run) begin
                if (!run_before || evt[1]) begin
                    m_cd = BASE_DIV >> new_speed;
                end else begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) begin
                        e_step = 1'b1;
                        m_cd   = BASE_DIV >> new_speed;
                    end
                end
            end
            e_enable = next_load || next_run;
            e_load_n = !next_load;
            e_dir    = (new_mode != 2);
            if (next_load) e_pin = (new_mode == 0) ? 8'h07 : sw_pattern;
            m_init = 1'b0; m_load = next_load; m_mode = new_mode;
            m_speed = new_speed; m_paused = new_paused;
            for (int b = 0; b < 3; b++) begin
                h[b] = {h[b][6:0], ~raw[b]};
                all_set = 1'b1;
                for (int k = 2; k < 2 + DB; k++) if (h[b][k] == lvl[b]) all_set = 1'b0;
                evt[b] = 1'b0;
                if (all_set) begin
                    lvl[b] = ~lvl[b];
                    evt[b] = lvl[b];
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({cnt_if.cnt_enable, cnt_if.cnt_load_n, cnt_if.cnt_direction, cnt_if.cnt_parallel_in,
                 cnt_if.cnt_step, mode, speed, paused} !==
                {e_enable, e_load_n, e_dir, e_pin, e_step, m_mode[1:0], m_speed[1:0], m_paused}) begin
                fails++;
                $display("FAIL model_cmp t=%0t got en=%b ld_n=%b dir=%b pin=%h step=%b mode=%0d spd=%0d p=%b exp en=%b ld_n=%b dir=%b pin=%h step=%b mode=%0d spd=%0d p=%b",
                         $time, cnt_if.cnt_enable, cnt_if.cnt_load_n, cnt_if.cnt_direction,
                         cnt_if.cnt_parallel_in, cnt_if.cnt_step, mode, speed, paused,
                         e_enable, e_load_n, e_dir, e_pin, e_step, m_mode, m_speed, m_paused);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_mode_n  = v;
            1:       btn_speed_n = v;
            default: btn_pause_n = v;
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count(input int n, output int loads, output int steps);
        loads = 0; steps = 0;
        repeat (n) begin
            @(negedge clk);
            loads += int'(!cnt_if.cnt_load_n);
            steps += int'(cnt_if.cnt_step);
        end
    endtask

    task automatic press(input int b, input int hold, input int tail, output int loads, output int steps);
        int l2, s2;
        set_btn(b, 1'b0);
        count(hold, loads, steps);
        set_btn(b, 1'b1);
        count(tail, l2, s2);
        loads += l2; steps += s2;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cnt_if.cnt_step && n < 200);
        if (!cnt_if.cnt_step) n = -1;
    endtask

    function automatic int outs_vec();
        return int'({cnt_if.cnt_enable, cnt_if.cnt_load_n, cnt_if.cnt_direction,
                     cnt_if.cnt_parallel_in, cnt_if.cnt_step, mode, speed, paused});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n, l, s, t;
        int exp_period [4];
        exp_period = '{8, 4, 2, 16};
        cyc(3);
        chk("rst_outs", outs_vec(), int'({1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 2'd0, 2'd0, 1'b0}));

        reset_n = 1'b1;
        @(negedge clk);
        chk("load_after_init", int'(cnt_if.cnt_load_n), 0);
        chk("load_seed", int'(cnt_if.cnt_parallel_in), 8'h07);
        wait_step(n); chk("first_step", n, 17);
        wait_step(n); chk("period_s0", n, 16);

        sw_pattern = 8'hA5;
        press(0, 10, 12, l, s);
        chk("mode1_loads", l, 1);
        chk("mode1", int'(mode), 1);
        chk("mode1_dir", int'(cnt_if.cnt_direction), 1);
        chk("mode1_pin", int'(cnt_if.cnt_parallel_in), 8'hA5);
        sw_pattern = 8'h3C;
        cyc(3);
        chk("pin_hold", int'(cnt_if.cnt_parallel_in), 8'hA5);
        press(0, 10, 12, l, s);
        chk("mode2", int'(mode), 2);
        chk("mode2_dir", int'(cnt_if.cnt_direction), 0);
        chk("mode2_pin", int'(cnt_if.cnt_parallel_in), 8'h3C);
        press(0, 10, 12, l, s);
        chk("mode0", int'(mode), 0);
        chk("mode0_pin", int'(cnt_if.cnt_parallel_in), 8'h07);

        l = 0;
        for (int i = 0; i < 12; i++) begin
            btn_mode_n = ((i % 4) >= 2);
            @(negedge clk);
            l += int'(!cnt_if.cnt_load_n);
        end
        chk("bounce_no_early_load", l, 0);
        btn_mode_n = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (cnt_if.cnt_load_n && t < 30);
        chk("bounce_latency", t, 7);
        count(10, l, s);
        chk("bounce_single", l, 0);
        btn_mode_n = 1'b1;
        cyc(10);
        chk("bounce_mode", int'(mode), 1);

        for (int k = 0; k < 4; k++) begin
            press(1, 8, 8, l, s);
            wait_step(n);
            wait_step(n);
            chk("speed_period", n, exp_period[k]);
        end

        press(2, 8, 8, l, s);
        chk("pause_en", int'(cnt_if.cnt_enable), 0);
        chk("pause_flag", int'(paused), 1);
        count(40, l, s);
        chk("pause_no_steps", s, 0);
        set_btn(2, 1'b0);
        t = 0;
        do begin @(negedge clk); t++; end while (!cnt_if.cnt_enable && t < 30);
        chk("resume_latency", t, 7);
        wait_step(n);
        chk("resume_first_step", n, 16);
        set_btn(2, 1'b1);
        cyc(8);
        press(2, 8, 8, l, s);
        press(0, 10, 10, l, s);
        chk("paused_mode_loads", l, 1);
        chk("paused_mode_en", int'(cnt_if.cnt_enable), 0);
        chk("paused_mode", int'(mode), 2);
        press(2, 8, 8, l, s);

        set_btn(0, 1'b0);
        t = 0;
        do begin @(negedge clk); t++; end while (cnt_if.cnt_load_n && t < 30);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_midload", outs_vec(), int'({1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 2'd0, 2'd0, 1'b0}));
        set_btn(0, 1'b1);
        cyc(2);
        reset_n = 1'b1;
        count(30, l, s);
        chk("post_rst_loads", l, 1);
        chk("post_rst_mode", int'(mode), 0);

        set_btn(1, 1'b0);
        cyc(4);
        reset_n = 1'b0;
        cyc(2);
        set_btn(1, 1'b1);
        reset_n = 1'b1;
        count(30, l, s);
        chk("middb_loads", l, 1);
        chk("middb_speed", int'(speed), 0);

        for (int it = 0; it < 200; it++) begin
            int b, hold;
            bit bouncy;
            b      = $urandom_range(0, 2);
            hold   = $urandom_range(1, 12);
            bouncy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) sw_pattern = 8'($urandom);
            for (int c = 0; c < hold; c++) begin
                set_btn(b, bouncy ? 1'($urandom_range(0, 1)) : 1'b0);
                @(negedge clk);
            end
            set_btn(b, 1'b1);
            cyc($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                cyc($urandom_range(1, 3));
                reset_n = 1'b1;
            end
        end
        cyc(20);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
